seg_scan_decoder: RTL
=====================

Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed seven-segment driver: samples the scanned `seg`/`an` bus plus the static number digit `seg1`, and reconstructs the four displayed characters and the song number as symbolic codes.
- Used as an on-board self-check and as the bench monitor for every display-producing block.
- Flags a frame once all four digit positions have been captured, and reports when the displayed text has been stable across several frames.

Parameters:
- SETTLE, 4: consecutive cycles a one-hot `an` must hold before its `seg` is captured (glitch rejection; must be ≥ 2).
- STABLE_FRAMES, 3: number of identical consecutive frames required before `stable` asserts.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- seg  in  8  scanned character pattern, bit order {dot,a,b,c,d,e,f,g}, active-high.
- an  in  4  digit select, active-high one-hot; an[0] selects slot 0 (leftmost character).
- seg1  in  8  static number digit pattern, same bit order.
- chars  out  20  four 5-bit codes, slot0 in [4:0] through slot3 in [19:15].
- num_out  out  4  decoded `seg1` value 0–9; 4'hF if the pattern is not a digit.
- frame_valid  out  1  one-cycle pulse when `chars` is updated.
- stable  out  1  high while the last STABLE_FRAMES frames are identical.
- err_an  out  1  one-cycle pulse on a multi-hot `an` sample.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - All state is updated on posedge clk.
  - `reset` is synchronous and active-high; reset dominates every other event in the same cycle.
- Reset values:
  - chars = four copies of BLANK (5'd18).
  - num_out = 4'hF.
  - frame_valid = 0, stable = 0, err_an = 0.
  - seen mask = 0000, settle counter = 0, stable counter = 0.
- Input stage:
  - `seg`, `an` and `seg1` are registered once (seg_q, an_q, seg1_q).
  - All decisions use the registered values.
- Pattern decode (combinational, shared function):
  - Digits:
    - 0 = 01111110
    - 1 = 00110000
    - 2 = 01101101
    - 3 = 01111001
    - 4 = 00110011
    - 5 = 01011011
    - 6 = 01011111
    - 7 = 01110000
    - 8 = 01111111
    - 9 = 01111011
    - These decode to codes 0–9.
  - Letters:
    - s = 01001001 → 10
    - t = 00001111 → 11
    - a = 01110111 → 12
    - r = 01000110 → 13
    - b = 00011111 → 14
    - d = 00111101 → 15
    - y = 00111011 → 16
    - e = 01001111 → 17
  - 00000000 → BLANK (18).
  - Any other pattern → UNKNOWN (31).
- num_out:
  - Updated every cycle from seg1_q.
  - Codes 0–9 pass through; any other code gives 4'hF.
  - Latency from `seg1` to num_out is 2 edges.
- Settle counter:
  - Cleared to 0 when an_q differs from its previous-cycle value, or when an_q is not one-hot.
  - Otherwise increments, saturating at SETTLE.
  - A capture occurs on the edge where the counter goes from SETTLE-1 to SETTLE, so each dwell produces exactly one capture.
  - Capture writes decode(seg_q) into the slot indexed by an_q and sets that slot's seen bit.
- Re-capture: capturing a slot already marked seen overwrites it; no error is raised.
- Frame completion:
  - Occurs on the capture edge that makes seen = 1111.
  - On that edge: `chars` is loaded with all four slots (including the new capture), frame_valid = 1 for one cycle, and seen is cleared.
- Stability tracking:
  - If the new frame equals the previous `chars`, the stable counter increments (saturating at STABLE_FRAMES); otherwise it is set to 1.
  - stable = (stable counter == STABLE_FRAMES), updated on the frame edge.
- an = 0000 (display off):
  - Clears the seen mask and the settle counter.
  - Keeps `chars`.
  - After SETTLE consecutive idle cycles, stable counter = 0 and stable = 0.
- Multi-hot `an`:
  - err_an pulses each cycle it is seen.
  - Settle counter cleared; no capture.
- Timing example: `an` changes before edge k → an_q updates at edge k → capture at edge k+SETTLE.

Decomposition:
- Shared package `seg_codes_pkg`:
  - the 8-bit pattern constants for digits and letters;
  - the 5-bit code constants, including BLANK and UNKNOWN;
  - the decode function.
- The letter constants are to be reused by the display driver.
- One sub-module, `seg_slot_capture`: the settle counter, one-hot check and seen mask, producing capture strobes and the slot index.

Test Plan:
- Scan "star" (patterns s,t,a,r), `an` cycling 0001→0010→0100→1000, 20 cycles each → frame_valid once per 80 cycles; chars = {13,12,11,10}.
- Hold "star" for 3 frames → stable rises on the third frame_valid; switch to "bday" → next frame chars = {16,12,15,14}, stable = 0.
- 2-cycle `an` glitch to 0100 inside a 20-cycle dwell of 0001 (SETTLE = 4) → no capture of slot 2; no early frame_valid.
- seg1 = 01101101 → num_out = 2 after 2 edges; seg1 = 01010101 → num_out = 4'hF.
- an = 0011 for 3 cycles → err_an high for 3 cycles; no capture; seen mask unchanged.
- Assert reset mid-frame after 2 slots captured → next frame needs all 4 new captures; chars read BLANK (18) until then; stable = 0.

Source files
------------

// File: rtl/seg_codes_pkg.sv
// Seven-segment pattern and symbolic code tables shared by the
// scan decoder and the display drivers.
package seg_codes_pkg;

  typedef logic [7:0] pat_t;
  typedef logic [4:0] code_t;

  // bit order {dot,a,b,c,d,e,f,g}, active-high
  localparam pat_t P_0     = 8'b0111_1110;
  localparam pat_t P_1     = 8'b0011_0000;
  localparam pat_t P_2     = 8'b0110_1101;
  localparam pat_t P_3     = 8'b0111_1001;
  localparam pat_t P_4     = 8'b0011_0011;
  localparam pat_t P_5     = 8'b0101_1011;
  localparam pat_t P_6     = 8'b0101_1111;
  localparam pat_t P_7     = 8'b0111_0000;
  localparam pat_t P_8     = 8'b0111_1111;
  localparam pat_t P_9     = 8'b0111_1011;
  localparam pat_t P_S     = 8'b0100_1001;
  localparam pat_t P_T     = 8'b0000_1111;
  localparam pat_t P_A     = 8'b0111_0111;
  localparam pat_t P_R     = 8'b0100_0110;
  localparam pat_t P_B     = 8'b0001_1111;
  localparam pat_t P_D     = 8'b0011_1101;
  localparam pat_t P_Y     = 8'b0011_1011;
  localparam pat_t P_E     = 8'b0100_1111;
  localparam pat_t P_BLANK = 8'b0000_0000;

  localparam code_t C_S     = 5'd10;
  localparam code_t C_T     = 5'd11;
  localparam code_t C_A     = 5'd12;
  localparam code_t C_R     = 5'd13;
  localparam code_t C_B     = 5'd14;
  localparam code_t C_D     = 5'd15;
  localparam code_t C_Y     = 5'd16;
  localparam code_t C_E     = 5'd17;
  localparam code_t C_BLANK = 5'd18;
  localparam code_t C_UNK   = 5'd31;

  function automatic code_t seg_decode(input pat_t p);
    code_t c;
    case (p)
      P_0:     c = 5'd0;
      P_1:     c = 5'd1;
      P_2:     c = 5'd2;
      P_3:     c = 5'd3;
      P_4:     c = 5'd4;
      P_5:     c = 5'd5;
      P_6:     c = 5'd6;
      P_7:     c = 5'd7;
      P_8:     c = 5'd8;
      P_9:     c = 5'd9;
      P_S:     c = C_S;
      P_T:     c = C_T;
      P_A:     c = C_A;
      P_R:     c = C_R;
      P_B:     c = C_B;
      P_D:     c = C_D;
      P_Y:     c = C_Y;
      P_E:     c = C_E;
      P_BLANK: c = C_BLANK;
      default: c = C_UNK;
    endcase
    return c;
  endfunction

  function automatic logic is_digit(input code_t c);
    return c < 5'd10;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Scanned display bus seen by the decoder, plus its decoded results.
interface seg_scan_decoder_if;

  logic [7:0]  seg;
  logic [3:0]  an;
  logic [7:0]  seg1;
  logic [19:0] chars;
  logic [3:0]  num_out;
  logic        frame_valid;
  logic        stable;
  logic        err_an;

  modport master (
    output seg, an, seg1,
    input  chars, num_out, frame_valid, stable, err_an
  );

  modport slave (
    input  seg, an, seg1,
    output chars, num_out, frame_valid, stable, err_an
  );

endinterface

// File: rtl/seg_slot_capture.sv
// Digit-select tracking: settle filter, one-hot check, seen mask,
// idle detection; emits capture/frame strobes and the slot index.
module seg_slot_capture #(
  parameter int SETTLE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_an,
  output logic       o_cap,
  output logic       o_frame,
  output logic       o_idle,
  output logic       o_multi,
  output logic [1:0] o_slot
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] C_MAX = CW'(SETTLE);
  localparam logic [CW-1:0] C_ARM = CW'(SETTLE - 1);

  logic [3:0]    r_an_prev;
  logic [3:0]    r_seen;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_idle;
  logic [CW-1:0] w_cnt_nx;
  logic          w_off;
  logic          w_onehot;
  logic          w_chg;

  always_comb begin
    w_off    = (i_an == 4'b0000);
    w_onehot = !w_off && ((i_an & (i_an - 4'd1)) == 4'b0000);
    w_chg    = (i_an != r_an_prev);
    o_multi  = !w_off && !w_onehot;
    o_slot   = {i_an[3] | i_an[2], i_an[3] | i_an[1]};
    // the cycle an_q changes already counts as the first of the dwell
    w_cnt_nx = r_cnt;
    if (!w_onehot)
      w_cnt_nx = '0;
    else if (w_chg)
      w_cnt_nx = CW'(1);
    else if (r_cnt != C_MAX)
      w_cnt_nx = r_cnt + 1'b1;
    o_cap   = w_onehot && !w_chg && (r_cnt == C_ARM);
    o_frame = o_cap && ((r_seen | i_an) == 4'b1111);
    o_idle  = (r_idle == C_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_an_prev <= 4'b0000;
      r_seen    <= 4'b0000;
      r_cnt     <= '0;
      r_idle    <= '0;
    end else begin
      r_an_prev <= i_an;
      r_cnt     <= w_cnt_nx;
      if (!w_off)
        r_idle <= '0;
      else if (r_idle != C_MAX)
        r_idle <= r_idle + 1'b1;
      if (w_off || o_frame)
        r_seen <= 4'b0000;
      else if (o_cap)
        r_seen <= r_seen | i_an;
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds the four scanned characters and the static number digit
// from a multiplexed seven-segment bus; tracks frame stability.
module seg_scan_decoder
  import seg_codes_pkg::*;
#(
  parameter int SETTLE        = 4,
  parameter int STABLE_FRAMES = 3
) (
  input logic             clk,
  input logic             reset,
  seg_scan_decoder_if.slave bus
);

  localparam int SW = $clog2(STABLE_FRAMES + 1);
  localparam logic [SW-1:0] S_MAX = SW'(STABLE_FRAMES);

  pat_t        r_seg_q;
  pat_t        r_seg1_q;
  logic [3:0]  r_an_q;
  code_t       r_slot [4];
  code_t       w_slots [4];
  logic [19:0] r_chars;
  logic [19:0] w_frame;
  logic [3:0]  r_num;
  logic        r_fv;
  logic        r_stable;
  logic        r_err;
  logic [SW-1:0] r_scnt;
  logic [SW-1:0] w_scnt_nx;
  logic        w_cap;
  logic        w_frame_go;
  logic        w_idle;
  logic        w_multi;
  logic [1:0]  w_slot;
  code_t       w_code;
  code_t       w_num_code;

  seg_slot_capture #(
    .SETTLE(SETTLE)
  ) u_cap (
    .clk     (clk),
    .reset   (reset),
    .i_an    (r_an_q),
    .o_cap   (w_cap),
    .o_frame (w_frame_go),
    .o_idle  (w_idle),
    .o_multi (w_multi),
    .o_slot  (w_slot)
  );

  always_comb begin
    w_code     = seg_decode(r_seg_q);
    w_num_code = seg_decode(r_seg1_q);
    for (int i = 0; i < 4; i++)
      w_slots[i] = (w_cap && w_slot == 2'(i))
                 ? w_code : r_slot[i];
    w_frame = {w_slots[3], w_slots[2], w_slots[1], w_slots[0]};
    w_scnt_nx = SW'(1);
    if (w_frame == r_chars)
      w_scnt_nx = (r_scnt == S_MAX) ? r_scnt : r_scnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg_q  <= '0;
      r_seg1_q <= '0;
      r_an_q   <= '0;
      for (int i = 0; i < 4; i++)
        r_slot[i] <= C_BLANK;
      r_chars  <= {4{C_BLANK}};
      r_num    <= 4'hF;
      r_fv     <= 1'b0;
      r_stable <= 1'b0;
      r_err    <= 1'b0;
      r_scnt   <= '0;
    end else begin
      r_seg_q  <= bus.seg;
      r_seg1_q <= bus.seg1;
      r_an_q   <= bus.an;
      r_slot   <= w_slots;
      r_num    <= is_digit(w_num_code) ? w_num_code[3:0] : 4'hF;
      r_fv     <= w_frame_go;
      r_err    <= w_multi;
      if (w_frame_go) begin
        r_chars  <= w_frame;
        r_scnt   <= w_scnt_nx;
        r_stable <= (w_scnt_nx == S_MAX);
      end else if (w_idle) begin
        r_scnt   <= '0;
        r_stable <= 1'b0;
      end
    end
  end

  assign bus.chars       = r_chars;
  assign bus.num_out     = r_num;
  assign bus.frame_valid = r_fv;
  assign bus.stable      = r_stable;
  assign bus.err_an      = r_err;

endmodule
